// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder, one FullAdder cell, LSB first, carry in a FF.
// Latency: Start accepted at edge E0 -> Done pulse in cycle after edge E0+WIDTH.
// Start is ignored while busy (ADD) or in the DONE cycle; no input backpressure.
//
// Ports:
//   Clk, Reset (async, active-high)
//   Start, Ain[WIDTH], Bin[WIDTH], CarryIn  -- request, sampled only in IDLE
//   Busy, Done, SumOut[WIDTH], CarryOut, Overflow -- status and held result
// Optional feature: define SERIAL_ADD_OVF_EN to compute signed Overflow;
// otherwise Overflow is tied to 0.

module FullAdder (
  input  logic Xin,
  input  logic Yin,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);
  assign Sum  = Xin ^ Yin ^ Cin;
  assign Cout = (Xin & Yin) | (Cin & (Xin ^ Yin));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] Ain,
  input  logic [WIDTH-1:0] Bin,
  input  logic             CarryIn,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] SumOut,
  output logic             CarryOut,
  output logic             Overflow
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] s_sr_q, s_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             fa_sum;
  logic             fa_cout;
  logic             last_bit;
  logic [WIDTH-1:0] s_sr_next;

  FullAdder u_fa (
    .Xin  (a_sr_q[0]),
    .Yin  (b_sr_q[0]),
    .Cin  (carry_q),
    .Sum  (fa_sum),
    .Cout (fa_cout)
  );

  assign last_bit  = (cnt_q == CW'(WIDTH - 1));
  // Sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  assign s_sr_next = {fa_sum, s_sr_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    s_sr_d  = s_sr_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          a_sr_d  = Ain;
          b_sr_d  = Bin;
          carry_d = CarryIn;
          cnt_d   = '0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        s_sr_d  = s_sr_next;
        carry_d = fa_cout;
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (last_bit) begin
          sum_d   = s_sr_next;
          cout_d  = fa_cout;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      s_sr_q  <= s_sr_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  logic ovf_q, ovf_d;

  // On the final bit edge carry_q is the carry into the MSB; signed overflow
  // is its XOR with the carry out of the MSB.
  assign ovf_d = (state_q == S_ADD && last_bit) ? (carry_q ^ fa_cout) : ovf_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign Overflow = ovf_q;
`else
  assign Overflow = 1'b0;
`endif

  assign Busy     = (state_q == S_ADD);
  assign Done     = (state_q == S_DONE);
  assign SumOut   = sum_q;
  assign CarryOut = cout_q;

endmodule
